// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing and test-pattern generator: pixel-rate divider, h/v counters,
// registered sync/active/coordinate/strobe outputs and a runtime-selectable RGB pattern.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CNT_W    = 12,
  parameter int unsigned COLOR_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   active,
  output logic [CNT_W-1:0]       x,
  output logic [CNT_W-1:0]       y,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned BAR_W   = H_ACTIVE / 8;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]       div_q;
  logic [CNT_W-1:0]       hc_q, vc_q, seg_q;
  logic [2:0]             bar_q;
  logic [1:0]             mode_q, mode_d;
  logic                   hsync_q, vsync_q, active_q, line_start_q, frame_start_q;
  logic [CNT_W-1:0]       x_q, y_q;
  logic [3*COLOR_W-1:0]   rgb_q, rgb_d;
  logic                   pix_tick, hc_last, vc_last, at_origin;
  logic                   h_act, v_act, h_syn, v_syn;

  always_comb begin
    pix_tick  = (div_q == DIV_W'(CLK_DIV - 1));
    hc_last   = (hc_q == CNT_W'(H_TOTAL - 1));
    vc_last   = (vc_q == CNT_W'(V_TOTAL - 1));
    at_origin = (hc_q == '0) && (vc_q == '0);
    h_act     = (hc_q < CNT_W'(H_ACTIVE));
    v_act     = (vc_q < CNT_W'(V_ACTIVE));
    h_syn     = (hc_q >= CNT_W'(H_ACTIVE + H_FP)) && (hc_q < CNT_W'(H_ACTIVE + H_FP + H_SYNC));
    v_syn     = (vc_q >= CNT_W'(V_ACTIVE + V_FP)) && (vc_q < CNT_W'(V_ACTIVE + V_FP + V_SYNC));
    // Pixel (0,0) already uses the newly sampled mode.
    mode_d    = (pix_tick && at_origin) ? mode : mode_q;
  end

  always_comb begin
    rgb_d = '0;
    if (h_act && v_act) begin
      unique case (mode_d)
        2'd1:    rgb_d = solid_rgb;
        2'd2:    rgb_d = {{COLOR_W{bar_q[2]}}, {COLOR_W{bar_q[1]}}, {COLOR_W{bar_q[0]}}};
        2'd3:    rgb_d = (hc_q[5] ^ vc_q[5]) ? '1 : '0;
        default: rgb_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      hc_q          <= '0;
      vc_q          <= '0;
      seg_q         <= '0;
      bar_q         <= '0;
      mode_q        <= '0;
      x_q           <= '0;
      y_q           <= '0;
      rgb_q         <= '0;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
    end else begin
      div_q         <= pix_tick ? '0 : div_q + DIV_W'(1);
      line_start_q  <= pix_tick && (hc_q == '0);
      frame_start_q <= pix_tick && at_origin;
      if (pix_tick) begin
        x_q      <= hc_q;
        y_q      <= vc_q;
        active_q <= h_act && v_act;
        hsync_q  <= h_syn ? HS_POL : ~HS_POL;
        vsync_q  <= v_syn ? VS_POL : ~VS_POL;
        rgb_q    <= rgb_d;
        mode_q   <= mode_d;
        hc_q     <= hc_last ? '0 : hc_q + CNT_W'(1);
        if (hc_last) vc_q <= vc_last ? '0 : vc_q + CNT_W'(1);
        // Bar index tracks hc: bumps after every BAR_W active pixels, cleared for hc=0.
        if (hc_last) begin
          seg_q <= '0;
          bar_q <= '0;
        end else if (h_act) begin
          if (seg_q == CNT_W'(BAR_W - 1)) begin
            seg_q <= '0;
            bar_q <= bar_q + 3'd1;
          end else begin
            seg_q <= seg_q + CNT_W'(1);
          end
        end
      end
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign red         = rgb_q[3*COLOR_W-1 -: COLOR_W];
  assign green       = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign blue        = rgb_q[COLOR_W-1:0];

endmodule
